// File: rtl/dm_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dm_cache_ctrl
// Brief    : Direct-mapped cache controller: tag/valid lookup, block refill on
//            read miss, write-through / no-write-allocate stores.
//            Optional hit/miss counters under DM_CACHE_CTRL_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dm_cache_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int NUM_BLOCKS  = 32,
    parameter int BLOCK_WORDS = 8,
    localparam int WORD_W     = $clog2(BLOCK_WORDS),
    localparam int OFFSET_W   = WORD_W + 2,
    localparam int INDEX_W    = $clog2(NUM_BLOCKS),
    localparam int TAG_W      = ADDR_W - OFFSET_W - INDEX_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req_valid,
    output logic                cpu_req_ready,
    input  logic                cpu_req_we,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    input  logic [31:0]         cpu_req_wdata,
    output logic                cpu_resp_valid,
    output logic [31:0]         cpu_resp_rdata,
    output logic                arr_we,
    output logic [INDEX_W-1:0]  arr_index,
    output logic [WORD_W-1:0]   arr_word,
    output logic [31:0]         arr_wdata,
    input  logic [31:0]         arr_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_ack,
    input  logic [31:0]         mem_rdata
`ifdef DM_CACHE_CTRL_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_REFILL = 3'd2,
        S_WTHRU  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    localparam logic [WORD_W-1:0] c_last_word = WORD_W'(BLOCK_WORDS - 1);

    state_t                 r_state;
    state_t                 w_next_state;
    logic                   r_we;
    logic [ADDR_W-3:0]      r_waddr;     // latched word address {tag, index, word}
    logic [31:0]            r_wdata;
    logic [31:0]            r_rdata;
    logic [WORD_W-1:0]      r_cnt;
    logic [NUM_BLOCKS-1:0]  r_valid;
    logic [TAG_W-1:0]       r_tag_ram [NUM_BLOCKS];

    logic [WORD_W-1:0]      w_word;
    logic [INDEX_W-1:0]     w_index;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic                   w_last;
    logic                   w_unused_addr_lsbs;

    assign w_word   = r_waddr[WORD_W-1:0];
    assign w_index  = r_waddr[WORD_W+INDEX_W-1:WORD_W];
    assign w_tag    = r_waddr[ADDR_W-3:WORD_W+INDEX_W];
    assign w_hit    = r_valid[w_index] & (r_tag_ram[w_index] == w_tag);
    assign w_last   = (r_cnt == c_last_word);
    assign w_unused_addr_lsbs = &{1'b0, cpu_req_addr[1:0]};

    assign cpu_resp_rdata = r_rdata;

    always_comb begin
        w_next_state   = r_state;
        cpu_req_ready  = 1'b0;
        cpu_resp_valid = 1'b0;
        arr_we         = 1'b0;
        arr_index      = w_index;
        arr_word       = w_word;
        arr_wdata      = '0;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        mem_addr       = '0;
        mem_wdata      = '0;
        case (r_state)
            S_IDLE: begin
                cpu_req_ready = 1'b1;
                arr_index     = cpu_req_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
                arr_word      = cpu_req_addr[OFFSET_W-1:2];
                if (cpu_req_valid) begin
                    w_next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (r_we) begin
                    arr_we       = w_hit;
                    arr_wdata    = r_wdata;
                    w_next_state = S_WTHRU;
                end else if (w_hit) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_REFILL;
                end
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_tag, w_index, r_cnt, 2'b00};
                arr_word = r_cnt;
                if (mem_ack) begin
                    arr_we    = 1'b1;
                    arr_wdata = mem_rdata;
                    if (w_last) begin
                        w_next_state = S_RESP;
                    end
                end
            end
            S_WTHRU: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {r_waddr, 2'b00};
                mem_wdata = r_wdata;
                if (mem_ack) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                cpu_resp_valid = 1'b1;
                w_next_state   = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_valid <= '0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req_valid) begin
                        r_we    <= cpu_req_we;
                        r_waddr <= cpu_req_addr[ADDR_W-1:2];
                        r_wdata <= cpu_req_wdata;
                    end
                end
                S_LOOKUP: begin
                    if (r_we) begin
                        r_rdata <= '0;
                    end else if (w_hit) begin
                        r_rdata <= arr_rdata;
                    end else begin
                        // Line is invalid until the final word lands, so an
                        // abandoned refill can never produce a false hit.
                        r_valid[w_index] <= 1'b0;
                        r_cnt            <= '0;
                    end
                end
                S_REFILL: begin
                    if (mem_ack) begin
                        if (r_cnt == w_word) begin
                            r_rdata <= mem_rdata;
                        end
                        if (w_last) begin
                            r_valid[w_index] <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + WORD_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Tag storage is deliberately not reset; r_valid qualifies every entry.
    always_ff @(posedge clk) begin
        if (r_state == S_REFILL && mem_ack && w_last) begin
            r_tag_ram[w_index] <= w_tag;
        end
    end

`ifdef DM_CACHE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else if (miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
